// File: rtl/l2_cache_control.sv
// l2_cache_control: sequencing controller for the 4-way, 8-set, 32-byte-line
// L2 cache datapath. It handles one upstream request at a time. Each request
// goes through lookup and compare. A miss runs an optional writeback and then
// a fill on the physical-memory port, and the lookup is replayed. The block
// also keeps hit and miss performance counters.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   mem_read, mem_write         upstream request, held until mem_resp
//   mem_resp                    one-cycle upstream completion pulse
//   pmem_read, pmem_write       physical-memory requests
//   pmem_resp                   physical-memory completion pulse
//   hit0..hit3, hit             datapath way-hit / any-hit flags
//   is_dirty                    dirty flag of the indexed set's victim
//   lru_out                     victim way index from the datapath LRU
//   *_read, compare_read        array read / compare enables
//   valid_load, dirty_load,
//   tag_load, dirty_in,
//   mbe_way_sel                 per-way load strobes, dirty value, line write enables
//   lru_load                    LRU update strobe
//   load_filldata               0: mem_wdata, 1: pmem_rdata
//   pmem_addr_muxsel            0: request line address, 1: victim tag address
//   hit_count, miss_count       wrapping performance counters
module l2_cache_control #(
    parameter int unsigned cnt_width = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mem_read,
    input  logic                 mem_write,
    output logic                 mem_resp,
    output logic                 pmem_read,
    output logic                 pmem_write,
    input  logic                 pmem_resp,
    input  logic                 hit0,
    input  logic                 hit1,
    input  logic                 hit2,
    input  logic                 hit3,
    input  logic                 hit,
    input  logic                 is_dirty,
    input  logic [1:0]           lru_out,
    output logic                 lru_read,
    output logic                 valid_read,
    output logic                 line_read,
    output logic                 dirty_read,
    output logic                 tag_read,
    output logic                 compare_read,
    output logic [3:0]           valid_load,
    output logic [3:0]           dirty_load,
    output logic [3:0]           tag_load,
    output logic [3:0]           dirty_in,
    output logic [3:0]           mbe_way_sel,
    output logic                 lru_load,
    output logic                 load_filldata,
    output logic                 pmem_addr_muxsel,
    output logic [cnt_width-1:0] hit_count,
    output logic [cnt_width-1:0] miss_count
);

    typedef enum logic [2:0] {
        IDLE,
        LOOKUP,
        COMPARE,
        WRITEBACK,
        FILL
    } state_t;

    state_t state;

    logic [3:0] hit_oh;
    logic [3:0] victim_oh;

    assign hit_oh    = {hit3, hit2, hit1, hit0};
    assign victim_oh = 4'b0001 << lru_out;

    // State sequencing and performance counters
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mem_read || mem_write) state <= LOOKUP;
                end
                LOOKUP: begin
                    state <= COMPARE;
                end
                COMPARE: begin
                    if (hit) begin
                        hit_count <= hit_count + cnt_width'(1);
                        state     <= IDLE;
                    end else begin
                        miss_count <= miss_count + cnt_width'(1);
                        state      <= is_dirty ? WRITEBACK : FILL;
                    end
                end
                WRITEBACK: begin
                    if (pmem_resp) state <= FILL;
                end
                FILL: begin
                    // Replay the lookup; the freshly loaded way now hits
                    if (pmem_resp) state <= LOOKUP;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Datapath and memory-port control decode
    always_comb begin
        mem_resp         = 1'b0;
        pmem_read        = 1'b0;
        pmem_write       = 1'b0;
        lru_read         = 1'b0;
        valid_read       = 1'b0;
        line_read        = 1'b0;
        dirty_read       = 1'b0;
        tag_read         = 1'b0;
        compare_read     = 1'b0;
        valid_load       = 4'b0000;
        dirty_load       = 4'b0000;
        tag_load         = 4'b0000;
        dirty_in         = 4'b0000;
        mbe_way_sel      = 4'b0000;
        lru_load         = 1'b0;
        load_filldata    = 1'b0;
        pmem_addr_muxsel = 1'b0;

        case (state)
            LOOKUP: begin
                lru_read     = 1'b1;
                valid_read   = 1'b1;
                line_read    = 1'b1;
                dirty_read   = 1'b1;
                tag_read     = 1'b1;
                compare_read = 1'b1;
            end
            COMPARE: begin
                lru_read     = 1'b1;
                valid_read   = 1'b1;
                line_read    = 1'b1;
                dirty_read   = 1'b1;
                tag_read     = 1'b1;
                compare_read = 1'b1;
                if (hit) begin
                    lru_load = 1'b1;
                    mem_resp = 1'b1;
                    // A write (including read+write) merges mem_wdata into the hit way
                    if (mem_write) begin
                        load_filldata = 1'b0;
                        mbe_way_sel   = hit_oh;
                        dirty_load    = hit_oh;
                        dirty_in      = hit_oh;
                    end
                end
            end
            WRITEBACK: begin
                pmem_write       = 1'b1;
                pmem_addr_muxsel = 1'b1;
                line_read        = 1'b1;
            end
            FILL: begin
                pmem_read     = 1'b1;
                load_filldata = 1'b1;
                if (pmem_resp) begin
                    mbe_way_sel = victim_oh;
                    tag_load    = victim_oh;
                    valid_load  = victim_oh;
                    dirty_load  = victim_oh;
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_l2_cache_control.sv
// Testbench for l2_cache_control. A small cache-array model stands in for the
// datapath and is driven only by the controller's strobes. A transaction-level
// reference cache predicts hit, victim, dirtiness, latency and counters. A
// second instance with 4-bit counters runs in lockstep to cover counter wrap.
module tb_l2_cache_control;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, mem_read, mem_write, pmem_resp;
    logic       hit0, hit1, hit2, hit3, hit, is_dirty;
    logic [1:0] lru_out;

    logic       mem_resp, pmem_read, pmem_write, lru_read, valid_read, line_read;
    logic       dirty_read, tag_read, compare_read, lru_load, load_filldata, pmem_addr_muxsel;
    logic [3:0] valid_load, dirty_load, tag_load, dirty_in, mbe_way_sel;
    logic [15:0] hit_count, miss_count;

    logic       w_mem_resp, w_pmem_read, w_pmem_write, w_lru_read, w_valid_read, w_line_read;
    logic       w_dirty_read, w_tag_read, w_compare_read, w_lru_load, w_load_filldata;
    logic       w_pmem_addr_muxsel;
    logic [3:0] w_valid_load, w_dirty_load, w_tag_load, w_dirty_in, w_mbe_way_sel;
    logic [3:0] w_hit_count, w_miss_count;

    logic [31:0] ctrl, wctrl;
    assign ctrl = {mem_resp, pmem_read, pmem_write, lru_read, valid_read, line_read,
                   dirty_read, tag_read, compare_read, lru_load, load_filldata,
                   pmem_addr_muxsel, valid_load, dirty_load, tag_load, dirty_in, mbe_way_sel};
    assign wctrl = {w_mem_resp, w_pmem_read, w_pmem_write, w_lru_read, w_valid_read,
                    w_line_read, w_dirty_read, w_tag_read, w_compare_read, w_lru_load,
                    w_load_filldata, w_pmem_addr_muxsel, w_valid_load, w_dirty_load,
                    w_tag_load, w_dirty_in, w_mbe_way_sel};

    l2_cache_control #(.cnt_width(16)) u_dut (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(mem_resp), .pmem_read(pmem_read), .pmem_write(pmem_write),
        .pmem_resp(pmem_resp), .hit0(hit0), .hit1(hit1), .hit2(hit2), .hit3(hit3),
        .hit(hit), .is_dirty(is_dirty), .lru_out(lru_out), .lru_read(lru_read),
        .valid_read(valid_read), .line_read(line_read), .dirty_read(dirty_read),
        .tag_read(tag_read), .compare_read(compare_read), .valid_load(valid_load),
        .dirty_load(dirty_load), .tag_load(tag_load), .dirty_in(dirty_in),
        .mbe_way_sel(mbe_way_sel), .lru_load(lru_load), .load_filldata(load_filldata),
        .pmem_addr_muxsel(pmem_addr_muxsel), .hit_count(hit_count), .miss_count(miss_count)
    );

    l2_cache_control #(.cnt_width(4)) u_dut_w4 (
        .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
        .mem_resp(w_mem_resp), .pmem_read(w_pmem_read), .pmem_write(w_pmem_write),
        .pmem_resp(pmem_resp), .hit0(hit0), .hit1(hit1), .hit2(hit2), .hit3(hit3),
        .hit(hit), .is_dirty(is_dirty), .lru_out(lru_out), .lru_read(w_lru_read),
        .valid_read(w_valid_read), .line_read(w_line_read), .dirty_read(w_dirty_read),
        .tag_read(w_tag_read), .compare_read(w_compare_read), .valid_load(w_valid_load),
        .dirty_load(w_dirty_load), .tag_load(w_tag_load), .dirty_in(w_dirty_in),
        .mbe_way_sel(w_mbe_way_sel), .lru_load(w_lru_load), .load_filldata(w_load_filldata),
        .pmem_addr_muxsel(w_pmem_addr_muxsel), .hit_count(w_hit_count),
        .miss_count(w_miss_count)
    );

    int checks = 0;
    int failures = 0;

    // Datapath stand-in, updated only by the controller's strobes
    logic [23:0] env_tag   [8][4];
    logic        env_valid [8][4];
    logic        env_dirty [8][4];
    int unsigned env_ts    [8][4];
    int unsigned now;

    // Reference cache: recency list per set, oldest first
    logic [23:0] ref_tag   [8][4];
    bit          ref_valid [8][4];
    bit          ref_dirty [8][4];
    int          ref_order [8][4];
    int unsigned ref_hits, ref_misses;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] oh(input int w);
        logic [3:0] r;
        r = 4'b0001 << w;
        return r;
    endfunction

    task automatic touch(input int s, input int w);
        int p;
        p = 0;
        for (int i = 0; i < 4; i++) if (ref_order[s][i] == w) p = i;
        for (int i = 0; i < 3; i++) if (i >= p) ref_order[s][i] = ref_order[s][i+1];
        ref_order[s][3] = w;
    endtask

    task automatic drive_env(input logic [2:0] s, input logic [23:0] t);
        logic [3:0] hv;
        int idx;
        for (int w = 0; w < 4; w++) hv[w] = env_valid[s][w] && (env_tag[s][w] == t);
        idx = 0;
        for (int w = 1; w < 4; w++) if (env_ts[s][w] < env_ts[s][idx]) idx = w;
        {hit3, hit2, hit1, hit0} = hv;
        hit      = |hv;
        lru_out  = 2'(idx);
        is_dirty = env_valid[s][idx] & env_dirty[s][idx];
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
            #2;
        end
        chk("idle_outputs", 64'({ctrl, wctrl}), 64'd0);
    endtask

    task automatic do_req(input bit rd, input bit wr, input logic [31:0] a,
                          input int wb_lat, input int fill_lat);
        logic [2:0]  s;
        logic [23:0] t, vtag;
        bit          exp_hit, exp_dirty, done, overlap, order_bad, bad, rd_seen;
        int          hw, vw, fw, exp_lat, cyc, resp_cyc, nwr, nrd, nlru, pcnt;
        logic [31:0] wb_addr, fill_addr;
        logic [15:0] fill_strb;
        logic [3:0]  fill_din, resp_mbe, resp_dl, resp_di, hv, mism;
        logic        resp_cmp, resp_lf;

        s = a[7:5]; t = a[31:8];
        exp_hit = 0; hw = 0;
        for (int w = 0; w < 4; w++)
            if (ref_valid[s][w] && ref_tag[s][w] == t) begin exp_hit = 1; hw = w; end
        vw        = ref_order[s][0];
        vtag      = ref_tag[s][vw];
        exp_dirty = !exp_hit && ref_valid[s][vw] && ref_dirty[s][vw];
        exp_lat   = exp_hit ? 2 : 4 + fill_lat + (exp_dirty ? wb_lat : 0);
        fw        = exp_hit ? hw : vw;

        done = 0; overlap = 0; order_bad = 0; bad = 0; rd_seen = 0;
        cyc = 0; resp_cyc = -1; nwr = 0; nrd = 0; nlru = 0; pcnt = 0;
        wb_addr = '0; fill_addr = '0; fill_strb = '0; fill_din = '0;
        resp_mbe = '0; resp_dl = '0; resp_di = '0; resp_cmp = 0; resp_lf = 0;

        while (!done && cyc < 300) begin
            @(negedge clk);
            mem_read = rd; mem_write = wr; pmem_resp = 1'b0;
            drive_env(s, t);
            #1;
            if (pmem_write)     pmem_resp = (pcnt == wb_lat - 1);
            else if (pmem_read) pmem_resp = (pcnt == fill_lat - 1);
            #1;
            if (cyc == 0) chk("request_start_idle", 64'({ctrl, wctrl}), 64'd0);
            if (pmem_read && pmem_write) overlap = 1;
            if (pmem_write) begin
                nwr++;
                if (rd_seen) order_bad = 1;
                if (!pmem_addr_muxsel || !line_read) bad = 1;
                if (pmem_resp)
                    wb_addr = pmem_addr_muxsel ? {env_tag[s][lru_out], s, 5'b0} : {a[31:5], 5'b0};
            end
            if (pmem_read) begin
                nrd++; rd_seen = 1;
                if (pmem_addr_muxsel || !load_filldata) bad = 1;
                if (pmem_resp) begin
                    fill_addr = pmem_addr_muxsel ? {env_tag[s][lru_out], s, 5'b0} : {a[31:5], 5'b0};
                    fill_strb = {mbe_way_sel, tag_load, valid_load, dirty_load};
                    fill_din  = dirty_in;
                end
            end
            if (lru_load) nlru++;
            if (mem_resp) begin
                done = 1; resp_cyc = cyc;
                resp_cmp = compare_read; resp_lf = load_filldata;
                resp_mbe = mbe_way_sel; resp_dl = dirty_load; resp_di = dirty_in;
            end
            // Array updates land at the coming clock edge
            hv = {hit3, hit2, hit1, hit0};
            for (int w = 0; w < 4; w++) begin
                if (tag_load[w])   env_tag[s][w]   = t;
                if (valid_load[w]) env_valid[s][w] = 1'b1;
                if (dirty_load[w]) env_dirty[s][w] = dirty_in[w];
                if (lru_load && hv[w]) begin now++; env_ts[s][w] = now; end
            end
            if (pmem_resp) pcnt = 0;
            else if (pmem_read || pmem_write) pcnt++;
            cyc++;
        end

        if (!done) begin
            chk("resp_timeout", 64'(cyc), 64'(exp_lat));
            return;
        end

        chk("resp_latency", 64'(resp_cyc), 64'(exp_lat));
        chk("wb_cycles", 64'(nwr), 64'(exp_dirty ? wb_lat : 0));
        chk("fill_cycles", 64'(nrd), 64'(exp_hit ? 0 : fill_lat));
        chk("pmem_protocol", 64'({overlap, order_bad, bad}), 64'd0);
        chk("lru_load_pulses", 64'(nlru), 64'd1);
        chk("resp_in_compare", 64'(resp_cmp), 64'd1);
        if (wr) chk("write_hit_strobes", 64'({resp_lf, resp_mbe, resp_dl, resp_di}),
                    64'({1'b0, oh(fw), oh(fw), oh(fw)}));
        else    chk("read_hit_strobes", 64'({resp_lf, resp_mbe, resp_dl, resp_di}), 64'd0);
        if (!exp_hit) begin
            chk("fill_addr", 64'(fill_addr), 64'({a[31:5], 5'b0}));
            chk("fill_strobes", 64'({fill_strb, fill_din}), 64'({oh(vw), oh(vw), oh(vw), oh(vw), 4'b0}));
        end
        if (exp_dirty) chk("wb_addr", 64'(wb_addr), 64'({vtag, s, 5'b0}));

        if (!exp_hit) begin
            ref_misses++;
            ref_tag[s][vw] = t; ref_valid[s][vw] = 1; ref_dirty[s][vw] = 0;
        end
        ref_hits++;
        if (wr) ref_dirty[s][fw] = 1;
        touch(s, fw);

        @(posedge clk);
        #1;
        chk("counters", 64'({hit_count, miss_count}), 64'({16'(ref_hits), 16'(ref_misses)}));
        chk("counters_w4", 64'({w_hit_count, w_miss_count}), 64'({4'(ref_hits), 4'(ref_misses)}));
        mism = '0;
        for (int w = 0; w < 4; w++)
            if (env_valid[s][w] !== ref_valid[s][w] || env_dirty[s][w] !== ref_dirty[s][w] ||
                (ref_valid[s][w] && env_tag[s][w] !== ref_tag[s][w])) mism[w] = 1'b1;
        chk("array_state", 64'(mism), 64'd0);
    endtask

    task automatic reset_mid_fill();
        logic [31:0] a;
        int nrd, cyc;
        bit fired;
        a = {24'd200, 3'd5, 5'd0};
        nrd = 0; cyc = 0; fired = 0;
        while (!fired && cyc < 100) begin
            @(negedge clk);
            mem_read = 1'b1; mem_write = 1'b0; pmem_resp = 1'b0;
            drive_env(a[7:5], a[31:8]);
            if (nrd == 2) rst = 1'b1;
            #1;
            if (pmem_write) pmem_resp = 1'b1;
            #1;
            if (rst) begin
                chk("rst_during_fill", 64'(pmem_read), 64'd1);
                fired = 1;
            end
            if (pmem_read) nrd++;
            cyc++;
        end
        if (!fired) chk("rst_fill_timeout", 64'(nrd), 64'd2);
        @(negedge clk);
        rst = 1'b0; mem_read = 1'b0; pmem_resp = 1'b0;
        #2;
        chk("rst_outputs", 64'({ctrl, wctrl}), 64'd0);
        chk("rst_counters", 64'({hit_count, miss_count, w_hit_count, w_miss_count}), 64'd0);
        ref_hits = 0; ref_misses = 0;
    endtask

    initial begin
        rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; pmem_resp = 1'b0;
        hit0 = 0; hit1 = 0; hit2 = 0; hit3 = 0; hit = 0; is_dirty = 0; lru_out = 2'd0;
        now = 3; ref_hits = 0; ref_misses = 0;
        for (int s = 0; s < 8; s++)
            for (int w = 0; w < 4; w++) begin
                env_tag[s][w] = '0; env_valid[s][w] = 0; env_dirty[s][w] = 0;
                env_ts[s][w] = w;
                ref_tag[s][w] = '0; ref_valid[s][w] = 0; ref_dirty[s][w] = 0;
                ref_order[s][w] = w;
            end

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        chk("reset_outputs", 64'({ctrl, wctrl}), 64'd0);
        chk("reset_counters", 64'({hit_count, miss_count, w_hit_count, w_miss_count}), 64'd0);

        // Warm-up write then read hit of the same line
        do_req(0, 1, 32'h0000_0100, 1, 3);
        idle(1);
        do_req(1, 0, 32'h0000_0100, 1, 1);
        idle(2);
        // Clean read miss with a 5-cycle fill
        do_req(1, 0, 32'h0000_0040, 1, 5);
        // Fill index 2 with dirty lines, then evict with a fifth tag (back-to-back)
        do_req(0, 1, 32'h0000_0140, 2, 2);
        do_req(0, 1, 32'h0000_0240, 3, 1);
        do_req(0, 1, 32'h0000_0340, 1, 4);
        do_req(0, 1, 32'h0000_0440, 2, 3);
        do_req(1, 0, 32'h0000_0540, 4, 2);
        // Write hit to a resident line, and simultaneous read+write
        do_req(0, 1, 32'h0000_0108, 1, 1);
        do_req(1, 1, 32'h0000_0544, 1, 1);
        idle(1);
        reset_mid_fill();

        for (int i = 0; i < 60; i++) begin
            logic [31:0] a;
            int kind;
            a = {24'($urandom_range(5, 0)), 3'($urandom_range(7, 0)), 5'($urandom_range(31, 0))};
            kind = int'($urandom_range(3, 0));
            do_req(kind != 1, kind == 1 || kind == 2, a,
                   int'($urandom_range(6, 1)), int'($urandom_range(6, 1)));
            if ($urandom_range(3, 0) == 0) idle(2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
